// File: rtl/trivium_pkg.sv
// ---------------------------------------------------------------------------
// trivium_pkg
// Shared types and defaults for the Trivium keystream FIFO controller.
//   triv_state_t        : controller sequencing states
//   TRIV_WARMUP_DEFAULT : core clocks discarded after key/IV load (4*288)
//   byte_t              : one FIFO byte
// ---------------------------------------------------------------------------
package trivium_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, WARMUP, RUN} triv_state_t;

    localparam int TRIV_WARMUP_DEFAULT = 1152;

    typedef logic [7:0] byte_t;

endpackage

// File: rtl/triv_byte_packer.sv
// ---------------------------------------------------------------------------
// triv_byte_packer
// Collects serial keystream bits MSB first and presents each completed byte
// as pending until the controller has written it to the FIFO.
// Ports:
//   clk, rst  : clock (rising edge), asynchronous active-low reset
//   clr       : synchronous clear of the partial byte and pending flag
//   shift_en  : accept bit_in this cycle
//   bit_in    : serial keystream bit
//   take      : the pending byte is written to the FIFO this cycle
//   byte_out  : last completed byte
//   pend      : byte_out holds a byte not yet written
// ---------------------------------------------------------------------------
module triv_byte_packer
    import trivium_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  shift_en,
    input  logic  bit_in,
    input  logic  take,
    output byte_t byte_out,
    output logic  pend
);

    // Only the seven most recent bits are ever needed: the eighth arrives on
    // bit_in in the cycle the byte completes.
    logic [6:0] shreg;
    logic [2:0] bit_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            byte_out <= '0;
            pend     <= 1'b0;
        end else if (clr) begin
            // byte_out is left as is; it is meaningless while pend is low.
            shreg   <= '0;
            bit_cnt <= '0;
            pend    <= 1'b0;
        end else begin
            if (shift_en) begin
                shreg   <= {shreg[5:0], bit_in};
                bit_cnt <= bit_cnt + 3'd1;
            end
            // A byte completing in the same cycle as a write keeps pend set.
            if (shift_en && bit_cnt == 3'd7) begin
                byte_out <= {shreg, bit_in};
                pend     <= 1'b1;
            end else if (take) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/trivium_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// trivium_fifo_ctrl
// Sequences a Trivium core (load, warm-up, run), packs its keystream into
// bytes, writes them to a flagless byte FIFO and serves consumer reads. The
// FIFO occupancy is tracked here; the core is stalled when the FIFO is full
// and a byte is already waiting, so no keystream bit is lost.
// Parameters: WARMUP_CYC, FIFO_DEPTH, LVL_W (must hold FIFO_DEPTH).
// Ports:
//   clk, rst    : clock (rising edge), asynchronous active-low reset
//   start, stop : pulses; start from IDLE, stop to IDLE from anywhere
//   ks_bit      : current core keystream bit
//   ks_load     : core loads key/IV
//   ks_en       : core advances at the next edge
//   fifo_din    : byte to FIFO
//   fifo_write  : FIFO write strobe
//   fifo_read   : FIFO read strobe
//   cons_req    : consumer requests one byte
//   cons_valid  : FIFO dout holds the requested byte this cycle
//   ready       : warm-up complete (RUN)
//   level       : bytes currently in the FIFO
//   fsm_state   : current controller state (observability)
//   stall_cnt   : RUN cycles with the core stalled (TRIV_CTRL_STATS_EN only)
// Build option: define TRIV_CTRL_STATS_EN to add stall_cnt.
// ---------------------------------------------------------------------------
module trivium_fifo_ctrl
    import trivium_pkg::*;
#(
    parameter int WARMUP_CYC = TRIV_WARMUP_DEFAULT,
    parameter int FIFO_DEPTH = 255,
    parameter int LVL_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             ks_bit,
    output logic             ks_load,
    output logic             ks_en,
    output byte_t            fifo_din,
    output logic             fifo_write,
    output logic             fifo_read,
    input  logic             cons_req,
    output logic             cons_valid,
    output logic             ready,
    output logic [LVL_W-1:0] level,
    output triv_state_t      fsm_state
`ifdef TRIV_CTRL_STATS_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    localparam int WARM_W = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYC - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

    triv_state_t       state, next_state;
    logic [WARM_W-1:0] warm_cnt;
    logic              pend;
    logic              full_stall;
    logic              shift_en;

    assign fsm_state = state;

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Stall only when a finished byte cannot leave: the core and the shift
    // register then freeze together, so the bit on ks_bit is kept.
    assign full_stall = pend && (level == LVL_FULL);

    always_comb begin
        next_state = state;
        ks_load    = 1'b0;
        ks_en      = 1'b0;
        ready      = 1'b0;
        case (state)
            IDLE:   if (start) next_state = LOAD;
            LOAD: begin
                ks_load    = 1'b1;
                next_state = WARMUP;
            end
            WARMUP: begin
                ks_en = 1'b1;
                if (warm_cnt == WARM_LAST) next_state = RUN;
            end
            RUN: begin
                ready = 1'b1;
                ks_en = !full_stall;
            end
            default: next_state = IDLE;
        endcase
        if (stop) next_state = IDLE;
    end

    // Counts only while staying in WARMUP; any exit (including stop) clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            warm_cnt <= '0;
        else if (state == WARMUP && next_state == WARMUP)
            warm_cnt <= warm_cnt + 1'b1;
        else
            warm_cnt <= '0;
    end

    // ------------------------------------------------------------------
    // Byte packing and write path
    // ------------------------------------------------------------------
    assign shift_en   = (state == RUN) && ks_en;
    assign fifo_write = pend && (level < LVL_FULL);

    triv_byte_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clr      (stop),
        .shift_en (shift_en),
        .bit_in   (ks_bit),
        .take     (fifo_write),
        .byte_out (fifo_din),
        .pend     (pend)
    );

    // ------------------------------------------------------------------
    // Read path. Handshake: cons_req is a one-cycle request; it is granted
    // (fifo_read=1) only when level!=0, otherwise it is dropped and the
    // consumer must ask again. A granted request is answered by cons_valid
    // exactly one cycle later, when the registered FIFO dout holds the byte.
    // ------------------------------------------------------------------
    assign fifo_read = cons_req && (level != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cons_valid <= 1'b0;
        else      cons_valid <= fifo_read;
    end

    // Occupancy; stop leaves it alone because the FIFO contents survive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= '0;
        end else begin
            case ({fifo_write, fifo_read})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

`ifdef TRIV_CTRL_STATS_EN
    // Saturating count of stalled RUN cycles; restarts with each accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (state == IDLE && start && !stop)
            stall_cnt <= '0;
        else if (state == RUN && !ks_en && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_trivium_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trivium_fifo_ctrl
// Bench for trivium_fifo_ctrl (FIFO_DEPTH=4, default warm-up). A stand-in
// core serves bits from a random table; a reference model derives expected
// bytes, FIFO level, read grants and stall behaviour from the keystream
// position and byte counts rather than from controller internals.
// ---------------------------------------------------------------------------
module tb_trivium_fifo_ctrl;
  import trivium_pkg::*;

  localparam int WARM  = 1152;
  localparam int DEPTH = 4;
  localparam int NBITS = 4096;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        cons_req = 1'b0;
  logic        ks_bit;
  logic        ks_load, ks_en, fifo_write, fifo_read, cons_valid, ready;
  byte_t       fifo_din;
  logic [7:0]  level;
  triv_state_t fsm_state;
`ifdef TRIV_CTRL_STATS_EN
  logic [15:0] stall_cnt;
`endif

  trivium_fifo_ctrl #(
    .WARMUP_CYC (WARM),
    .FIFO_DEPTH (DEPTH),
    .LVL_W      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .ks_bit     (ks_bit),
    .ks_load    (ks_load),
    .ks_en      (ks_en),
    .fifo_din   (fifo_din),
    .fifo_write (fifo_write),
    .fifo_read  (fifo_read),
    .cons_req   (cons_req),
    .cons_valid (cons_valid),
    .ready      (ready),
    .level      (level),
    .fsm_state  (fsm_state)
`ifdef TRIV_CTRL_STATS_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- stand-in core ----------------
  logic        core_bits [0:NBITS-1];
  logic [11:0] pos;
  bit          pattern_a5 = 1'b1;

  assign ks_bit = core_bits[pos];

  always @(posedge clk or negedge rst) begin
    if (!rst)         pos <= '0;
    else if (ks_load) pos <= '0;
    else if (ks_en)   pos <= pos + 12'd1;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [7:0] exp_q[$];
  int         m_level  = 0;
  bit         exp_cv   = 1'b0;
  bit         sess     = 1'b0;
  int         bytes_wr = 0;

  always @(negedge clk) begin : model
    int   run_bits;
    bit   pend_m, exp_rd, exp_wr;
    logic [7:0] b;
    if (!rst) begin
      m_level  = 0;
      exp_cv   = 1'b0;
      sess     = 1'b0;
      bytes_wr = 0;
      exp_q.delete();
    end else begin
      run_bits = (sess && int'(pos) >= WARM) ? int'(pos) - WARM : 0;
      pend_m   = sess && ((run_bits / 8) > bytes_wr);
      exp_wr   = pend_m && (m_level < DEPTH);
      exp_rd   = cons_req && (m_level != 0);
      check("level", 32'(level), 32'(m_level));
      check("cons_valid", 32'(cons_valid), 32'(exp_cv));
      check("fifo_read", 32'(fifo_read), 32'(exp_rd));
      check("fifo_write", 32'(fifo_write), 32'(exp_wr));
      if (ready) check("ks_en_run", 32'(ks_en), 32'(!(pend_m && m_level == DEPTH)));
      if (fifo_write) begin
        if (exp_q.size() == 0) check("byte_avail", 32'd0, 32'd1);
        else check("fifo_din", 32'(fifo_din), 32'(exp_q.pop_front()));
      end
      if (exp_wr) bytes_wr++;
      m_level = m_level + (exp_wr ? 1 : 0) - (exp_rd ? 1 : 0);
      exp_cv  = exp_rd;
      if (ks_load) begin
        for (int i = 0; i < NBITS; i++) core_bits[i] = 1'($urandom_range(0, 1));
        if (pattern_a5) begin
          b = 8'hA5;
          for (int i = 0; i < 8; i++) core_bits[WARM + i] = b[7 - i];
        end
        exp_q.delete();
        for (int n = 0; n < (NBITS - WARM) / 8; n++) begin
          b = '0;
          for (int i = 0; i < 8; i++) b = {b[6:0], core_bits[WARM + 8 * n + i]};
          exp_q.push_back(b);
        end
        sess     = 1'b1;
        bytes_wr = 0;
      end
      if (stop) begin
        sess = 1'b0;
        exp_q.delete();
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int cyc, warm, lvl_before;
    bit done;

    for (int i = 0; i < NBITS; i++) core_bits[i] = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ks_load", 32'(ks_load), 32'd0);
    check("rst_ks_en", 32'(ks_en), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_din", 32'(fifo_din), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(IDLE));
    step();
    rst = 1'b1;
    step();

    // Warm-up timing: start in cycle 0, ks_load in cycle 1
    start = 1'b1;
    @(negedge clk);
    check("load_not_yet", 32'(ks_load), 32'd0);
    step();
    start = 1'b0;
    @(negedge clk);
    check("ks_load_cycle1", 32'(ks_load), 32'd1);
    warm = 0;
    cyc  = 0;
    while (1) begin
      step();
      @(negedge clk);
      if (ready || cyc >= 3000) break;
      cyc++;
      if (ks_en) warm++;
    end
    check("ready_timing", 32'(cyc), 32'(WARM));
    check("warmup_ks_en", 32'(warm), 32'(WARM));

    // Packing: first byte is the A5 pattern, eight RUN cycles in
    check("pack_level0", 32'(level), 32'd0);
    cyc = 0;
    while (!fifo_write && cyc < 20) begin
      step();
      @(negedge clk);
      cyc++;
    end
    check("pack_latency", 32'(cyc), 32'd8);
    check("pack_a5", 32'(fifo_din), 32'hA5);
    step();
    @(negedge clk);
    check("pack_level1", 32'(level), 32'd1);

    // start while running is ignored
    pulse_start();
    @(negedge clk);
    check("start_ignored_load", 32'(ks_load), 32'd0);
    check("start_ignored_ready", 32'(ready), 32'd1);

    // Full stall
    cyc = 0;
    while (!(level == 8'(DEPTH) && !ks_en) && cyc < 200) begin
      step();
      cyc++;
    end
    @(negedge clk);
    check("stall_ks_en", 32'(ks_en), 32'd0);
    check("stall_level", 32'(level), 32'(DEPTH));
    repeat (3) step();
    @(negedge clk);
    check("stall_hold", 32'(ks_en), 32'd0);
    step();
    cons_req = 1'b1;
    @(negedge clk);
    check("stall_read", 32'(fifo_read), 32'd1);
    check("stall_no_write", 32'(fifo_write), 32'd0);
    step();
    cons_req = 1'b0;
    @(negedge clk);
    check("stall_refill_write", 32'(fifo_write), 32'd1);
    check("stall_mid_level", 32'(level), 32'(DEPTH - 1));
    step();
    @(negedge clk);
    check("stall_level_after", 32'(level), 32'(DEPTH));

    // Simultaneous read and write at level 2
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 200) begin
      step();
      cyc++;
      cons_req = 1'b0;
      if (level == 8'd2 && fifo_write) begin
        cons_req = 1'b1;
        @(negedge clk);
        check("simul_rd", 32'(fifo_read), 32'd1);
        check("simul_wr", 32'(fifo_write), 32'd1);
        step();
        cons_req = 1'b0;
        @(negedge clk);
        check("simul_level", 32'(level), 32'd2);
        check("simul_valid", 32'(cons_valid), 32'd1);
        done = 1'b1;
      end else if (level > 8'd2 && !fifo_write) begin
        cons_req = 1'b1;
      end
    end
    check("simul_found", 32'(done), 32'd1);

    // Stop with five bits of a partial byte collected
    cyc = 0;
    step();
    while (!(ready && ((int'(pos) - WARM) % 8) == 5) && cyc < 20) begin
      step();
      cyc++;
    end
    lvl_before = int'(level);
    stop = 1'b1;
    step();
    stop = 1'b0;
    @(negedge clk);
    check("stop_ready", 32'(ready), 32'd0);
    check("stop_state", 32'(fsm_state), 32'(IDLE));
    check("stop_level", 32'(level), 32'(lvl_before));
    repeat (20) step();
    @(negedge clk);
    check("stop_level_hold", 32'(level), 32'(lvl_before));
    check("stop_ks_en", 32'(ks_en), 32'd0);

    // Drain, then request from an empty FIFO
    cons_req = 1'b1;
    cyc = 0;
    while (level != 8'd0 && cyc < 10) begin
      step();
      cyc++;
    end
    @(negedge clk);
    check("empty_level", 32'(level), 32'd0);
    check("empty_no_read", 32'(fifo_read), 32'd0);
    step();
    cons_req = 1'b0;
    @(negedge clk);
    check("empty_no_valid", 32'(cons_valid), 32'd0);

    // Reset in the middle of warm-up
    pattern_a5 = 1'b0;
    pulse_start();
    repeat (100) step();
    rst = 1'b0;
    #1;
    check("mid_rst_ks_en", 32'(ks_en), 32'd0);
    check("mid_rst_ks_load", 32'(ks_load), 32'd0);
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_write", 32'(fifo_write), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_state", 32'(fsm_state), 32'(IDLE));
    step();
    rst = 1'b1;
    step();

    // Randomised consumer traffic in a fresh session
    pulse_start();
    cyc = 0;
    while (!ready && cyc < 1300) begin
      step();
      cyc++;
    end
    check("rand_ready", 32'(ready), 32'd1);
    for (int blk = 0; blk < 12; blk++) begin
      int thr;
      thr = $urandom_range(0, 10);
      for (int k = 0; k < 100; k++) begin
        step();
        cons_req = ($urandom_range(0, 9) < thr);
      end
    end
    step();
    cons_req = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
